// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the hazard/memory/divider sources and pipe_ctrl.
// master drives the requests; slave (pipe_ctrl) drives the stage controls.
interface pipe_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stall_from_Load;
    logic             flush_from_Load;
    logic             br_taken_EX;
    logic             imem_ready;
    logic             dmem_req_MEM;
    logic             dmem_ready;
    logic             div_start_EX;
    logic             div_done;
    logic             stall_PC;
    logic             stall_IFID;
    logic             stall_IDEX;
    logic             stall_EXMEM;
    logic             flush_IFID;
    logic             flush_IDEX;
    logic             flush_EXMEM;
    logic             flush_MEMWB;
    logic             mem_timeout_err;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output stall_from_Load, flush_from_Load, br_taken_EX, imem_ready,
               dmem_req_MEM, dmem_ready, div_start_EX, div_done,
        input  stall_PC, stall_IFID, stall_IDEX, stall_EXMEM,
               flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
               mem_timeout_err, stall_cycles
    );

    modport slave (
        input  stall_from_Load, flush_from_Load, br_taken_EX, imem_ready,
               dmem_req_MEM, dmem_ready, div_start_EX, div_done,
        output stall_PC, stall_IFID, stall_IDEX, stall_EXMEM,
               flush_IFID, flush_IDEX, flush_EXMEM, flush_MEMWB,
               mem_timeout_err, stall_cycles
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush arbiter for the 5-stage LA32 core: divide tracking,
// wrong-path fetch kill, dmem-wait watchdog and stall-cycle counter.
module pipe_ctrl #(
    parameter int unsigned TO_W  = 8,
    parameter int unsigned CNT_W = 32
) (
    input logic        clk,
    input logic        rstn,
    pipe_ctrl_if.slave bus
);
    localparam logic [0:0]       S_RUN      = 1'b0;
    localparam logic [0:0]       S_DIV_WAIT = 1'b1;
    localparam logic [TO_W-1:0]  WD_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [0:0]       r_state, w_state_nxt;
    logic             r_done_seen, w_done_seen_nxt;
    logic             r_kill_pending, w_kill_nxt;
    logic [TO_W-1:0]  r_wd_cnt, w_wd_nxt;
    logic             r_mem_timeout_err;
    logic [CNT_W-1:0] r_stall_cycles;

    logic w_dw, w_db, w_row3, w_kill_fire;
    logic w_stall_pc, w_stall_ifid, w_stall_idex, w_stall_exmem;
    logic w_flush_ifid, w_flush_idex, w_flush_exmem, w_flush_memwb;

    // Priority arbitration of stage controls; a forced IF/ID flush drops a wrong-path fetch.
    always_comb begin
        w_stall_pc    = 1'b0;
        w_stall_ifid  = 1'b0;
        w_stall_idex  = 1'b0;
        w_stall_exmem = 1'b0;
        w_flush_ifid  = 1'b0;
        w_flush_idex  = 1'b0;
        w_flush_exmem = 1'b0;
        w_flush_memwb = 1'b0;
        w_row3        = 1'b0;
        w_kill_fire   = 1'b0;

        w_dw = bus.dmem_req_MEM & ~bus.dmem_ready;
        w_db = ((r_state == S_DIV_WAIT) & ~bus.div_done & ~r_done_seen) |
               ((r_state == S_RUN) & bus.div_start_EX & ~bus.div_done);

        if (w_dw) begin
            w_stall_pc    = 1'b1;
            w_stall_ifid  = 1'b1;
            w_stall_idex  = 1'b1;
            w_stall_exmem = 1'b1;
            w_flush_memwb = 1'b1;
        end else if (w_db) begin
            w_stall_pc    = 1'b1;
            w_stall_ifid  = 1'b1;
            w_stall_idex  = 1'b1;
            w_flush_exmem = 1'b1;
        end else if (bus.br_taken_EX) begin
            w_row3        = 1'b1;
            w_flush_ifid  = 1'b1;
            w_flush_idex  = 1'b1;
        end else if (bus.stall_from_Load | bus.flush_from_Load) begin
            w_stall_pc    = 1'b1;
            w_stall_ifid  = 1'b1;
            w_flush_idex  = 1'b1;
        end else if (!bus.imem_ready) begin
            w_stall_pc    = 1'b1;
            w_flush_ifid  = 1'b1;
        end

        if (r_kill_pending && bus.imem_ready && !w_dw && !w_db) begin
            w_kill_fire  = 1'b1;
            w_flush_ifid = 1'b1;
        end

        if (!rstn) begin
            w_stall_pc    = 1'b0;
            w_stall_ifid  = 1'b0;
            w_stall_idex  = 1'b0;
            w_stall_exmem = 1'b0;
            w_flush_ifid  = 1'b1;
            w_flush_idex  = 1'b1;
            w_flush_exmem = 1'b1;
            w_flush_memwb = 1'b1;
        end
    end

    // Next-state: divide FSM, kill tracking and watchdog count.
    always_comb begin
        w_state_nxt     = r_state;
        w_done_seen_nxt = r_done_seen;
        w_kill_nxt      = r_kill_pending;
        w_wd_nxt        = '0;

        case (r_state)
            S_RUN: begin
                if (bus.div_start_EX && !bus.div_done && !w_dw)
                    w_state_nxt = S_DIV_WAIT;
            end
            S_DIV_WAIT: begin
                if ((bus.div_done || r_done_seen) && !w_dw) begin
                    w_state_nxt     = S_RUN;
                    w_done_seen_nxt = 1'b0;
                end else if (bus.div_done && w_dw) begin
                    w_done_seen_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase

        if (w_row3)
            w_kill_nxt = r_kill_pending | ~bus.imem_ready;
        else if (w_kill_fire)
            w_kill_nxt = 1'b0;

        if (w_dw)
            w_wd_nxt = (r_wd_cnt == WD_MAX) ? r_wd_cnt : r_wd_cnt + TO_W'(1);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state           <= S_RUN;
            r_done_seen       <= 1'b0;
            r_kill_pending    <= 1'b0;
            r_wd_cnt          <= '0;
            r_mem_timeout_err <= 1'b0;
            r_stall_cycles    <= '0;
        end else begin
            r_state           <= w_state_nxt;
            r_done_seen       <= w_done_seen_nxt;
            r_kill_pending    <= w_kill_nxt;
            r_wd_cnt          <= w_wd_nxt;
            r_mem_timeout_err <= r_mem_timeout_err | (w_wd_nxt == WD_MAX);
            if (w_stall_pc && (r_stall_cycles != CNT_MAX))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign bus.stall_PC        = w_stall_pc;
    assign bus.stall_IFID      = w_stall_ifid;
    assign bus.stall_IDEX      = w_stall_idex;
    assign bus.stall_EXMEM     = w_stall_exmem;
    assign bus.flush_IFID      = w_flush_ifid;
    assign bus.flush_IDEX      = w_flush_idex;
    assign bus.flush_EXMEM     = w_flush_exmem;
    assign bus.flush_MEMWB     = w_flush_memwb;
    assign bus.mem_timeout_err = r_mem_timeout_err;
    assign bus.stall_cycles    = r_stall_cycles;
endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus random traffic
// compared against a behavioural model of the arbitration rules.
module tb_pipe_ctrl;
    localparam int unsigned TO_W   = 3;
    localparam int unsigned CNT_W  = 8;
    localparam int          WD_TOP = (1 << TO_W) - 1;
    localparam int          CNT_TOP = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();
    pipe_ctrl #(.TO_W(TO_W), .CNT_W(CNT_W)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: divide outstanding, result banked during a wait, etc.
    bit m_div_busy, m_banked, m_kill, m_err;
    int m_wait, m_cnt;
    // Per-cycle model results
    int         m_lvl;
    bit         m_dw, m_fire;
    logic [7:0] m_exp;
    // Stage controls per priority level: {stall PC,IFID,IDEX,EXMEM, flush IFID,IDEX,EXMEM,MEMWB}
    logic [7:0] lvl_tab [1:6];

    // Stimulus fields: {ld, fl, br, im, dq, dr, ds, dd}
    task automatic drive(input logic [7:0] s);
        bus.stall_from_Load = s[7];
        bus.flush_from_Load = s[6];
        bus.br_taken_EX     = s[5];
        bus.imem_ready      = s[4];
        bus.dmem_req_MEM    = s[3];
        bus.dmem_ready      = s[2];
        bus.div_start_EX    = s[1];
        bus.div_done        = s[0];
    endtask

    function automatic logic [7:0] obs();
        return {bus.stall_PC, bus.stall_IFID, bus.stall_IDEX, bus.stall_EXMEM,
                bus.flush_IFID, bus.flush_IDEX, bus.flush_EXMEM, bus.flush_MEMWB};
    endfunction

    task automatic model_reset();
        m_div_busy = 0; m_banked = 0; m_kill = 0; m_err = 0;
        m_wait = 0; m_cnt = 0;
    endtask

    task automatic model_eval();
        bit db;
        m_dw = bus.dmem_req_MEM && !bus.dmem_ready;
        db   = m_div_busy ? (!bus.div_done && !m_banked)
                          : (bus.div_start_EX && !bus.div_done);
        if (m_dw)                                        m_lvl = 1;
        else if (db)                                     m_lvl = 2;
        else if (bus.br_taken_EX)                        m_lvl = 3;
        else if (bus.stall_from_Load || bus.flush_from_Load) m_lvl = 4;
        else if (!bus.imem_ready)                        m_lvl = 5;
        else                                             m_lvl = 6;
        m_exp  = lvl_tab[m_lvl];
        m_fire = m_kill && bus.imem_ready && (m_lvl > 2);
        if (m_fire) m_exp[3] = 1'b1;
    endtask

    task automatic model_commit();
        if (m_exp[7] && m_cnt < CNT_TOP) m_cnt++;
        if (m_dw) begin
            if (m_wait < WD_TOP) m_wait++;
        end else begin
            m_wait = 0;
        end
        if (m_wait == WD_TOP) m_err = 1;
        if (!m_div_busy) begin
            if (bus.div_start_EX && !bus.div_done && !m_dw) m_div_busy = 1;
        end else if ((bus.div_done || m_banked) && !m_dw) begin
            m_div_busy = 0; m_banked = 0;
        end else if (bus.div_done && m_dw) begin
            m_banked = 1;
        end
        if (m_lvl == 3)  m_kill = m_kill || !bus.imem_ready;
        else if (m_fire) m_kill = 0;
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
        #1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(8'h10);
        model_reset();
        @(negedge clk);
        n_checks++;
        if (obs() !== 8'h0F) begin
            n_fail++; $display("FAIL reset_ctrl got=%h want=0f", obs());
        end
        n_checks++;
        if (bus.mem_timeout_err !== 1'b0 || bus.stall_cycles !== '0) begin
            n_fail++; $display("FAIL reset_regs got err=%b cnt=%0d want 0/0", bus.mem_timeout_err, bus.stall_cycles);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_load_use();
        logic [7:0] stim [2] = '{8'hD0, 8'h10};
        logic [7:0] want [2] = '{8'hC4, 8'h00};
        for (int i = 0; i < 2; i++) begin
            drive(stim[i]);
            @(negedge clk); model_eval();
            n_checks++;
            if (obs() !== want[i] || obs() !== m_exp) begin
                n_fail++; $display("FAIL load_use[%0d] got=%h want=%h model=%h", i, obs(), want[i], m_exp);
            end
            advance();
        end
        n_checks++;
        if (bus.stall_cycles !== CNT_W'(1)) begin
            n_fail++; $display("FAIL load_use_cnt got=%0d want=1", bus.stall_cycles);
        end
    endtask

    task automatic test_dmem_wait();
        logic [7:0] stim [4] = '{8'h18, 8'h38, 8'h18, 8'h1C};
        logic [7:0] want [4] = '{8'hF1, 8'hF1, 8'hF1, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            @(negedge clk); model_eval();
            n_checks++;
            if (obs() !== want[i] || obs() !== m_exp) begin
                n_fail++; $display("FAIL dmem_wait[%0d] got=%h want=%h model=%h", i, obs(), want[i], m_exp);
            end
            advance();
        end
        n_checks++;
        if (bus.stall_cycles !== CNT_W'(m_cnt)) begin
            n_fail++; $display("FAIL dmem_wait_cnt got=%0d want=%0d", bus.stall_cycles, m_cnt);
        end
    endtask

    task automatic test_div_overlap();
        logic [7:0] stim [9] = '{8'h12, 8'h10, 8'h10, 8'h10, 8'h19, 8'h18, 8'h10, 8'h10, 8'h13};
        logic [7:0] want [9] = '{8'hE2, 8'hE2, 8'hE2, 8'hE2, 8'hF1, 8'hF1, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) begin
            drive(stim[i]);
            @(negedge clk); model_eval();
            n_checks++;
            if (obs() !== want[i] || obs() !== m_exp) begin
                n_fail++; $display("FAIL div_overlap[%0d] got=%h want=%h model=%h", i, obs(), want[i], m_exp);
            end
            advance();
        end
    endtask

    task automatic test_kill_fetch();
        logic [7:0] stim [4] = '{8'h20, 8'h00, 8'h10, 8'h10};
        logic [7:0] want [4] = '{8'h0C, 8'h88, 8'h08, 8'h00};
        for (int i = 0; i < 4; i++) begin
            drive(stim[i]);
            @(negedge clk); model_eval();
            n_checks++;
            if (obs() !== want[i] || obs() !== m_exp) begin
                n_fail++; $display("FAIL kill_fetch[%0d] got=%h want=%h model=%h", i, obs(), want[i], m_exp);
            end
            advance();
        end
    endtask

    task automatic test_watchdog();
        for (int i = 0; i < 12; i++) begin
            drive(i < 10 ? 8'h18 : 8'h10);
            @(negedge clk); model_eval();
            n_checks++;
            if (bus.mem_timeout_err !== ((i >= WD_TOP) ? 1'b1 : 1'b0) || bus.mem_timeout_err !== m_err) begin
                n_fail++; $display("FAIL watchdog[%0d] got=%b want=%b", i, bus.mem_timeout_err, (i >= WD_TOP));
            end
            advance();
        end
        #1 rstn = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if (obs() !== 8'h0F || bus.mem_timeout_err !== 1'b0 || bus.stall_cycles !== '0) begin
            n_fail++; $display("FAIL async_reset got ctrl=%h err=%b cnt=%0d want 0f/0/0", obs(), bus.mem_timeout_err, bus.stall_cycles);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < CNT_TOP + 5; i++) begin
            drive(8'h90);
            @(negedge clk); model_eval();
            advance();
        end
        drive(8'h10);
        @(negedge clk);
        n_checks++;
        if (bus.stall_cycles !== CNT_W'(CNT_TOP) || int'(bus.stall_cycles) != m_cnt) begin
            n_fail++; $display("FAIL cnt_saturate got=%0d want=%0d", bus.stall_cycles, CNT_TOP);
        end
        #1 rstn = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    task automatic test_random();
        logic [7:0] s;
        for (int i = 0; i < 400; i++) begin
            s[7] = ($urandom_range(0, 99) < 15);
            s[6] = ($urandom_range(0, 99) < 10);
            s[5] = ($urandom_range(0, 99) < 15);
            s[4] = ($urandom_range(0, 99) < 70);
            s[3] = ($urandom_range(0, 99) < 30);
            s[2] = ($urandom_range(0, 99) < 50);
            s[1] = ($urandom_range(0, 99) < 10);
            s[0] = ($urandom_range(0, 99) < 15);
            drive(s);
            @(negedge clk); model_eval();
            n_checks++;
            if (obs() !== m_exp) begin
                n_fail++; $display("FAIL random_ctrl[%0d] stim=%h got=%h want=%h", i, s, obs(), m_exp);
            end
            n_checks++;
            if (bus.mem_timeout_err !== m_err || int'(bus.stall_cycles) != m_cnt) begin
                n_fail++; $display("FAIL random_regs[%0d] got err=%b cnt=%0d want err=%b cnt=%0d",
                                   i, bus.mem_timeout_err, bus.stall_cycles, m_err, m_cnt);
            end
            advance();
        end
    endtask

    initial begin
        lvl_tab[1] = 8'hF1;
        lvl_tab[2] = 8'hE2;
        lvl_tab[3] = 8'h0C;
        lvl_tab[4] = 8'hC4;
        lvl_tab[5] = 8'h88;
        lvl_tab[6] = 8'h00;
        test_reset();
        test_load_use();
        test_dmem_wait();
        test_div_overlap();
        test_kill_fetch();
        test_watchdog();
        test_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
